// File: rtl/icb_arb2.sv
// Two-master to one-slave ICB arbiter for the shared data-memory port.
// Round-robin on ties, grant lock while a forwarded command stalls, in-order owner FIFO for responses.
module icb_arb2 #(
  parameter int OUTS = 4,
  parameter int PW   = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_icb_cmd_valid,
  output logic        m0_icb_cmd_ready,
  input  logic [31:0] m0_icb_cmd_addr,
  input  logic        m0_icb_cmd_read,
  input  logic [31:0] m0_icb_cmd_wdata,
  input  logic [3:0]  m0_icb_cmd_wmask,
  output logic        m0_icb_rsp_valid,
  input  logic        m0_icb_rsp_ready,
  output logic [31:0] m0_icb_rsp_rdata,

  input  logic        m1_icb_cmd_valid,
  output logic        m1_icb_cmd_ready,
  input  logic [31:0] m1_icb_cmd_addr,
  input  logic        m1_icb_cmd_read,
  input  logic [31:0] m1_icb_cmd_wdata,
  input  logic [3:0]  m1_icb_cmd_wmask,
  output logic        m1_icb_rsp_valid,
  input  logic        m1_icb_rsp_ready,
  output logic [31:0] m1_icb_rsp_rdata,

  output logic        s_icb_cmd_valid,
  input  logic        s_icb_cmd_ready,
  output logic [31:0] s_icb_cmd_addr,
  output logic        s_icb_cmd_read,
  output logic [31:0] s_icb_cmd_wdata,
  output logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_rsp_valid,
  output logic        s_icb_rsp_ready,
  input  logic [31:0] s_icb_rsp_rdata,

  output logic        busy
);

  logic          last_id_q, last_id_d;
  logic          lock_q, lock_d;
  logic          locked_id_q, locked_id_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [OUTS-1:0] own_q;

  logic grant;
  logic g_valid;
  logic full;
  logic empty;
  logic head;
  logic cmd_acc;
  logic cmd_stall;
  logic rsp_acc;

  // A stalled command keeps its master granted so the slave sees stable fields.
  always_comb begin
    grant = 1'b0;
    if (lock_q) begin
      grant = locked_id_q;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      grant = ~last_id_q;
    end else if (m1_icb_cmd_valid) begin
      grant = 1'b1;
    end
  end

  assign full  = (cnt_q == (PW+1)'(OUTS));
  assign empty = (cnt_q == '0);
  assign busy  = ~empty;

  assign g_valid         = grant ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign s_icb_cmd_valid = g_valid & ~full;
  assign s_icb_cmd_addr  = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read  = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  assign m0_icb_cmd_ready = ~grant & s_icb_cmd_ready & ~full;
  assign m1_icb_cmd_ready =  grant & s_icb_cmd_ready & ~full;

  assign cmd_acc   = s_icb_cmd_valid &  s_icb_cmd_ready;
  assign cmd_stall = s_icb_cmd_valid & ~s_icb_cmd_ready;

  // Responses return in order, so the FIFO head names their owner.
  assign head = own_q[rptr_q];

  assign m0_icb_rsp_valid = ~head & s_icb_rsp_valid & ~empty;
  assign m1_icb_rsp_valid =  head & s_icb_rsp_valid & ~empty;
  assign m0_icb_rsp_rdata = head ? 32'h0 : s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = head ? s_icb_rsp_rdata : 32'h0;

  assign s_icb_rsp_ready = (head ? m1_icb_rsp_ready : m0_icb_rsp_ready) & ~empty;
  assign rsp_acc         = s_icb_rsp_valid & s_icb_rsp_ready;

  always_comb begin
    last_id_d   = last_id_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    if (cmd_acc) begin
      last_id_d = grant;
      lock_d    = 1'b0;
      wptr_d    = wptr_q + 1'b1;
    end else if (cmd_stall) begin
      lock_d      = 1'b1;
      locked_id_d = grant;
    end
    if (rsp_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({cmd_acc, rsp_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q   <= 1'b1;
      lock_q      <= 1'b0;
      locked_id_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      last_id_q   <= last_id_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Owner entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      own_q[wptr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_icb_arb2.sv
// Directed bench for icb_arb2: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_icb_arb2;

  logic        clk;
  logic        rst_n;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready;
  logic [31:0] m0_icb_rsp_rdata;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready;
  logic [31:0] m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready;
  logic [31:0] s_icb_rsp_rdata;
  logic        busy;

  int n_chk;
  int n_fail;

  icb_arb2 #(.OUTS(4), .PW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_icb_cmd_valid = 1'b0; m0_icb_cmd_addr = 32'h0; m0_icb_cmd_read = 1'b1;
    m0_icb_cmd_wdata = 32'h0; m0_icb_cmd_wmask = 4'h0; m0_icb_rsp_ready = 1'b0;
    m1_icb_cmd_valid = 1'b0; m1_icb_cmd_addr = 32'h0; m1_icb_cmd_read = 1'b1;
    m1_icb_cmd_wdata = 32'h0; m1_icb_cmd_wmask = 4'h0; m1_icb_rsp_ready = 1'b0;
    s_icb_cmd_ready = 1'b0; s_icb_rsp_valid = 1'b0; s_icb_rsp_rdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_s_cmd_valid", 32'(s_icb_cmd_valid), 0);
    chk("rst_m0_cmd_ready", 32'(m0_icb_cmd_ready), 0);
    chk("rst_m1_cmd_ready", 32'(m1_icb_cmd_ready), 0);
    chk("rst_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
    chk("rst_m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
    chk("rst_s_rsp_ready", 32'(s_icb_rsp_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // m1 alone: 8 reads, slave answers one cycle after each accept
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m1_icb_cmd_valid = (i < 8);
      m1_icb_cmd_addr  = 32'h4000_0000 + 32'(4 * i);
      m1_icb_cmd_read  = 1'b1;
      m1_icb_rsp_ready = 1'b1;
      s_icb_cmd_ready  = 1'b1;
      s_icb_rsp_valid  = (i >= 1 && i <= 8);
      s_icb_rsp_rdata  = (32'h4000_0000 + 32'(4 * (i - 1))) ^ 32'hA5A5_A5A5;
      #1;
      if (i < 8) begin
        chk("t1_s_addr", s_icb_cmd_addr, 32'h4000_0000 + 32'(4 * i));
        chk("t1_s_read", 32'(s_icb_cmd_read), 1);
        chk("t1_m1_cmd_ready", 32'(m1_icb_cmd_ready), 1);
      end
      if (i >= 1 && i <= 8) begin
        chk("t1_m1_rsp_valid", 32'(m1_icb_rsp_valid), 1);
        chk("t1_m1_rdata", m1_icb_rsp_rdata, (32'h4000_0000 + 32'(4 * (i - 1))) ^ 32'hA5A5_A5A5);
      end
      chk("t1_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
      chk("t1_busy", 32'(busy), (i >= 1 && i <= 8) ? 1 : 0);
    end

    // both masters valid from reset: alternating grants, responses routed by owner
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m0_icb_cmd_valid = (i < 4);
      m0_icb_cmd_addr  = 32'h1000_0000 + 32'(i);
      m0_icb_cmd_read  = 1'b1;
      m1_icb_cmd_valid = (i < 4);
      m1_icb_cmd_addr  = 32'h2000_0000 + 32'(i);
      m1_icb_cmd_read  = 1'b0;
      m1_icb_cmd_wdata = 32'hCAFE_0000 + 32'(i);
      m1_icb_cmd_wmask = 4'h3;
      m0_icb_rsp_ready = 1'b1;
      m1_icb_rsp_ready = 1'b1;
      s_icb_cmd_ready  = 1'b1;
      s_icb_rsp_valid  = (i >= 1 && i <= 4);
      s_icb_rsp_rdata  = 32'hBEEF_0000 + 32'(i);
      #1;
      if (i < 4) begin
        if (i % 2 == 0) begin
          chk("t2_s_addr_m0", s_icb_cmd_addr, 32'h1000_0000 + 32'(i));
          chk("t2_s_read_m0", 32'(s_icb_cmd_read), 1);
        end else begin
          chk("t2_s_addr_m1", s_icb_cmd_addr, 32'h2000_0000 + 32'(i));
          chk("t2_s_read_m1", 32'(s_icb_cmd_read), 0);
          chk("t2_s_wdata_m1", s_icb_cmd_wdata, 32'hCAFE_0000 + 32'(i));
          chk("t2_s_wmask_m1", 32'(s_icb_cmd_wmask), 32'h3);
        end
        chk("t2_m0_cmd_ready", 32'(m0_icb_cmd_ready), (i % 2 == 0) ? 1 : 0);
        chk("t2_m1_cmd_ready", 32'(m1_icb_cmd_ready), (i % 2 == 1) ? 1 : 0);
      end
      if (i >= 1 && i <= 4) begin
        chk("t2_m0_rsp_valid", 32'(m0_icb_rsp_valid), ((i - 1) % 2 == 0) ? 1 : 0);
        chk("t2_m1_rsp_valid", 32'(m1_icb_rsp_valid), ((i - 1) % 2 == 1) ? 1 : 0);
        if ((i - 1) % 2 == 0) begin
          chk("t2_m0_rdata", m0_icb_rsp_rdata, 32'hBEEF_0000 + 32'(i));
          chk("t2_m1_rdata_zero", m1_icb_rsp_rdata, 0);
        end else begin
          chk("t2_m1_rdata", m1_icb_rsp_rdata, 32'hBEEF_0000 + 32'(i));
          chk("t2_m0_rdata_zero", m0_icb_rsp_rdata, 0);
        end
      end
      if (i == 5) chk("t2_busy_end", 32'(busy), 0);
    end

    // lock: one m0 accept first so that m1 would win an unlocked tie
    do_reset();
    @(negedge clk);
    idle();
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h3000_0000; s_icb_cmd_ready = 1'b1;
    #1;
    chk("t3_warm_m0_ready", 32'(m0_icb_cmd_ready), 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h3000_0010;
      m1_icb_cmd_valid = (j >= 1); m1_icb_cmd_addr = 32'h3000_0020;
      s_icb_cmd_ready  = (j == 3);
      #1;
      chk("t3_lock_addr", s_icb_cmd_addr, 32'h3000_0010);
      chk("t3_lock_m1_ready", 32'(m1_icb_cmd_ready), 0);
      chk("t3_lock_m0_ready", 32'(m0_icb_cmd_ready), (j == 3) ? 1 : 0);
    end
    @(negedge clk);
    m0_icb_cmd_addr = 32'h3000_0030; s_icb_cmd_ready = 1'b1;
    #1;
    chk("t3_after_addr", s_icb_cmd_addr, 32'h3000_0020);
    chk("t3_after_m1_ready", 32'(m1_icb_cmd_ready), 1);
    chk("t3_after_m0_ready", 32'(m0_icb_cmd_ready), 0);
    @(negedge clk);
    m1_icb_cmd_valid = 1'b0;
    #1;
    chk("t3_fill_m0_ready", 32'(m0_icb_cmd_ready), 1);

    // FIFO full: four outstanding, owners m0,m0,m1,m0
    @(negedge clk);
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h3000_0040;
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h3000_0050;
    #1;
    chk("t4_full_s_valid", 32'(s_icb_cmd_valid), 0);
    chk("t4_full_m0_ready", 32'(m0_icb_cmd_ready), 0);
    chk("t4_full_m1_ready", 32'(m1_icb_cmd_ready), 0);
    chk("t4_full_busy", 32'(busy), 1);
    chk("t4_full_cnt", 32'(dut.cnt_q), 4);
    @(negedge clk);
    s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h1111_1111;
    m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
    #1;
    chk("t4_pop_m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
    chk("t4_pop_m0_rdata", m0_icb_rsp_rdata, 32'h1111_1111);
    chk("t4_pop_s_rsp_ready", 32'(s_icb_rsp_ready), 1);
    chk("t4_pop_s_valid_blocked", 32'(s_icb_cmd_valid), 0);
    @(negedge clk);
    s_icb_rsp_valid = 1'b0;
    #1;
    chk("t4_next_s_valid", 32'(s_icb_cmd_valid), 1);
    chk("t4_next_addr", s_icb_cmd_addr, 32'h3000_0050);
    chk("t4_next_m1_ready", 32'(m1_icb_cmd_ready), 1);

    // response backpressure: pop the m0 head, then stall m1 at the head
    @(negedge clk);
    m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
    s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h2222_2222;
    #1;
    chk("t5_pre_m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_icb_rsp_rdata = 32'h3333_3333; m1_icb_rsp_ready = 1'b0; m0_icb_rsp_ready = 1'b1;
      #1;
      chk("t5_stall_m1_rsp_valid", 32'(m1_icb_rsp_valid), 1);
      chk("t5_stall_m1_rdata", m1_icb_rsp_rdata, 32'h3333_3333);
      chk("t5_stall_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
      chk("t5_stall_s_rsp_ready", 32'(s_icb_rsp_ready), 0);
      chk("t5_stall_cnt", 32'(dut.cnt_q), 3);
    end
    @(negedge clk);
    m1_icb_rsp_ready = 1'b1;
    #1;
    chk("t5_rel_s_rsp_ready", 32'(s_icb_rsp_ready), 1);
    @(negedge clk);
    s_icb_rsp_rdata = 32'h4444_4444; m0_icb_rsp_ready = 1'b0; m1_icb_rsp_ready = 1'b0;
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h3000_0060;
    #1;
    chk("t5_head_m0_rsp_valid", 32'(m0_icb_rsp_valid), 1);
    chk("t5_head_m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
    chk("t5_third_m0_ready", 32'(m0_icb_cmd_ready), 1);

    // reset with three outstanding; the pending response must vanish
    @(negedge clk);
    rst_n = 1'b0;
    m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
    m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
    s_icb_rsp_valid = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_s_cmd_valid", 32'(s_icb_cmd_valid), 0);
    chk("t6_rst_m0_rsp_valid", 32'(m0_icb_rsp_valid), 0);
    chk("t6_rst_m1_rsp_valid", 32'(m1_icb_rsp_valid), 0);
    chk("t6_rst_s_rsp_ready", 32'(s_icb_rsp_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    m0_icb_cmd_valid = 1'b1; m0_icb_cmd_addr = 32'h5000_0000;
    m1_icb_cmd_valid = 1'b1; m1_icb_cmd_addr = 32'h6000_0000;
    s_icb_cmd_ready = 1'b1;
    #1;
    chk("t6_resume_addr0", s_icb_cmd_addr, 32'h5000_0000);
    chk("t6_resume_m0_ready", 32'(m0_icb_cmd_ready), 1);
    @(negedge clk);
    #1;
    chk("t6_resume_addr1", s_icb_cmd_addr, 32'h6000_0000);
    chk("t6_resume_m1_ready", 32'(m1_icb_cmd_ready), 1);

    @(negedge clk);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
